// File: rtl/fdiv_generic.sv
// fdiv_generic: iterative IEEE-754 divider, parameterised on exponent/fraction width.
// Restoring radix-2 divide, one quotient bit per cycle, RNE rounding, subnormals flushed.
module fdiv_generic #(
    parameter int EXP_W  = 11,
    parameter int MANT_W = 52,
    localparam int W     = 1 + EXP_W + MANT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ena,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res,
    output logic         o_valid,
    output logic         o_busy,
    output logic         o_illegal_op,
    output logic         o_divbyzero,
    output logic         o_overflow,
    output logic         o_underflow,
    output logic         o_inexact
);
    localparam int XW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MANT_W + 3);
    localparam logic        [XW-1:0] BIAS_X   = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 ** EXP_W - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t r_state, w_next;

    logic [W-1:0]          r_a, r_b;
    logic                  r_sign;
    logic signed [XW-1:0]  r_exp;
    logic [MANT_W+1:0]     r_rem;
    logic [MANT_W:0]       r_mb;
    logic [MANT_W+2:0]     r_q;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_spec, r_spec_inv, r_spec_dz;
    logic [W-1:0]          r_spec_res;
    logic [W-1:0]          r_res;
    logic                  r_inv, r_dz, r_ov, r_uf, r_nx;

    // ---------------- unpack / classification ----------------
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MANT_W-1:0] w_fa, w_fb;
    logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sa, w_sb, w_sign;
    logic [MANT_W:0]   w_ma, w_mb;
    logic [XW-1:0]     w_ediff;
    logic              w_spec, w_spec_inv, w_spec_dz;
    logic [W-1:0]      w_spec_res;

    assign w_ea = r_a[W-2:MANT_W];
    assign w_eb = r_b[W-2:MANT_W];
    assign w_fa = r_a[MANT_W-1:0];
    assign w_fb = r_b[MANT_W-1:0];
    // Zero exponent covers subnormals: they are flushed to zero on input.
    assign w_za = (w_ea == '0);
    assign w_zb = (w_eb == '0);
    assign w_ia = (&w_ea) && (w_fa == '0);
    assign w_ib = (&w_eb) && (w_fb == '0);
    assign w_na = (&w_ea) && (w_fa != '0);
    assign w_nb = (&w_eb) && (w_fb != '0);
    assign w_sa = w_na && !w_fa[MANT_W-1];
    assign w_sb = w_nb && !w_fb[MANT_W-1];
    assign w_sign  = r_a[W-1] ^ r_b[W-1];
    assign w_ma    = w_za ? '0 : {1'b1, w_fa};
    assign w_mb    = w_zb ? '0 : {1'b1, w_fb};
    assign w_ediff = {2'b00, w_ea} - {2'b00, w_eb} + BIAS_X;

    // Special-case result; these bypass the datapath but keep the fixed latency.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_dz  = 1'b0;
        w_spec_res = '0;
        if (w_na || w_nb) begin
            w_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            w_spec_inv = w_sa || w_sb;
        end else if ((w_za && w_zb) || (w_ia && w_ib)) begin
            w_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            w_spec_inv = 1'b1;
        end else if (w_ia) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (w_zb) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            w_spec_dz  = 1'b1;
        end else if (w_za || w_ib) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec     = 1'b0;
        end
    end

    // ---------------- divide step ----------------
    logic              w_ge;
    logic [MANT_W+1:0] w_diff;
    assign w_ge   = (r_rem >= {1'b0, r_mb});
    assign w_diff = r_rem - (w_ge ? {1'b0, r_mb} : '0);

    // ---------------- normalise / round / range ----------------
    logic [MANT_W+2:0]    w_qn;
    logic signed [XW-1:0] w_expn, w_expr;
    logic [MANT_W:0]      w_mant;
    logic                 w_g, w_rs, w_up;
    logic [MANT_W+1:0]    w_mantr;
    logic [MANT_W-1:0]    w_frac;
    logic [W-1:0]         w_res;
    logic                 w_ov, w_uf, w_nx;

    // Normalise the quotient to [1,2), round to nearest even, then range-check.
    always_comb begin
        w_qn   = r_q[MANT_W+2] ? r_q : {r_q[MANT_W+1:0], 1'b0};
        w_expn = r_q[MANT_W+2] ? r_exp : r_exp - XW'(1);
        w_mant = w_qn[MANT_W+2:2];
        w_g    = w_qn[1];
        w_rs   = w_qn[0] | (r_rem != '0);
        w_up   = w_g & (w_rs | w_mant[0]);
        w_mantr = {1'b0, w_mant} + {{(MANT_W+1){1'b0}}, w_up};
        w_expr = w_expn + {{(XW-1){1'b0}}, w_mantr[MANT_W+1]};
        w_frac = w_mantr[MANT_W+1] ? w_mantr[MANT_W:1] : w_mantr[MANT_W-1:0];
        w_ov   = (w_expr >= EXP_MAX);
        w_uf   = (w_expr <= EXP_ZERO);
        w_nx   = w_g | w_rs | w_ov | w_uf;
        if (w_ov)
            w_res = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (w_uf)
            w_res = {r_sign, {(W-1){1'b0}}};
        else
            w_res = {r_sign, w_expr[EXP_W-1:0], w_frac};
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; the counter sets the DIVIDE dwell.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_ena) w_next = S_UNPACK;
            S_UNPACK: w_next = S_DIVIDE;
            S_DIVIDE: if (r_cnt == '0) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_valid = (r_state == S_DONE);
        o_busy  = (r_state != S_IDLE);
    end

    // Datapath registers, advanced per state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_exp <= '0;
            r_rem <= '0; r_mb <= '0; r_q <= '0; r_cnt <= '0;
            r_spec <= 1'b0; r_spec_inv <= 1'b0; r_spec_dz <= 1'b0; r_spec_res <= '0;
            r_res <= '0; r_inv <= 1'b0; r_dz <= 1'b0; r_ov <= 1'b0; r_uf <= 1'b0; r_nx <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_ena) begin
                    r_a <= i_a;
                    r_b <= i_b;
                end
                S_UNPACK: begin
                    r_sign     <= w_sign;
                    r_exp      <= w_ediff;
                    r_rem      <= {1'b0, w_ma};
                    r_mb       <= w_mb;
                    r_q        <= '0;
                    r_cnt      <= CNT_W'(MANT_W + 2);
                    r_spec     <= w_spec;
                    r_spec_inv <= w_spec_inv;
                    r_spec_dz  <= w_spec_dz;
                    r_spec_res <= w_spec_res;
                end
                S_DIVIDE: begin
                    r_rem <= w_diff << 1;
                    r_q   <= {r_q[MANT_W+1:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_ROUND: begin
                    if (r_spec) begin
                        r_res <= r_spec_res; r_inv <= r_spec_inv; r_dz <= r_spec_dz;
                        r_ov  <= 1'b0; r_uf <= 1'b0; r_nx <= 1'b0;
                    end else begin
                        r_res <= w_res; r_inv <= 1'b0; r_dz <= 1'b0;
                        r_ov  <= w_ov; r_uf <= w_uf; r_nx <= w_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_res        = r_res;
    assign o_illegal_op = r_inv;
    assign o_divbyzero  = r_dz;
    assign o_overflow   = r_ov;
    assign o_underflow  = r_uf;
    assign o_inexact    = r_nx;

endmodule

// File: tb/tb_fdiv_generic.sv
// Directed bench for fdiv_generic: F64 and F32 instances, scoreboard queue of expected results.
module tb_fdiv_generic;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        d_ena, s_ena;
    logic [63:0] d_a, d_b, d_res;
    logic [31:0] s_a, s_b, s_res;
    logic d_valid, d_busy, d_inv, d_dz, d_ov, d_uf, d_nx;
    logic s_valid, s_busy, s_inv, s_dz, s_ov, s_uf, s_nx;

    fdiv_generic #(.EXP_W(11), .MANT_W(52)) u_f64 (
        .i_clk(clk), .i_rst(rst), .i_ena(d_ena), .i_a(d_a), .i_b(d_b),
        .o_res(d_res), .o_valid(d_valid), .o_busy(d_busy), .o_illegal_op(d_inv),
        .o_divbyzero(d_dz), .o_overflow(d_ov), .o_underflow(d_uf), .o_inexact(d_nx));

    fdiv_generic #(.EXP_W(8), .MANT_W(23)) u_f32 (
        .i_clk(clk), .i_rst(rst), .i_ena(s_ena), .i_a(s_a), .i_b(s_b),
        .o_res(s_res), .o_valid(s_valid), .o_busy(s_busy), .o_illegal_op(s_inv),
        .o_divbyzero(s_dz), .o_overflow(s_ov), .o_underflow(s_uf), .o_inexact(s_nx));

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;   // {illegal, divbyzero, overflow, underflow, inexact}
        int          lat;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] flags(input bit f32);
        return f32 ? {s_inv, s_dz, s_ov, s_uf, s_nx} : {d_inv, d_dz, d_ov, d_uf, d_nx};
    endfunction

    // Start one op, optionally re-pulse i_ena at cycle pulse_at, compare when o_valid appears.
    task automatic run(input string tag, input bit f32, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [4:0] flg, input int pulse_at);
        exp_t e;
        int   cyc;
        bit   got;
        sb.push_back('{res: res, flg: flg, lat: (f32 ? 29 : 58)});
        @(negedge clk);
        if (f32) begin s_ena = 1'b1; s_a = a[31:0]; s_b = b[31:0]; end
        else     begin d_ena = 1'b1; d_a = a;       d_b = b;       end
        @(posedge clk);
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            // Operands scrambled after the start edge must not matter.
            d_a = ~a; d_b = 64'h3FF0000000000000; s_a = ~a[31:0]; s_b = 32'h3F800000;
            d_ena = 1'b0; s_ena = 1'b0;
            if (cyc == pulse_at) begin d_ena = !f32; s_ena = f32; end
            if (f32 ? s_valid : d_valid) begin got = 1'b1; break; end
            @(posedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, " done"}, 64'(got), 64'd1);
        chk({tag, " res"}, f32 ? {32'b0, s_res} : d_res, e.res);
        chk({tag, " flags"}, 64'(flags(f32)), 64'(e.flg));
        chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
        @(negedge clk);
        chk({tag, " valid 1cyc"}, 64'(f32 ? s_valid : d_valid), 64'd0);
        chk({tag, " idle"}, 64'(f32 ? s_busy : d_busy), 64'd0);
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (d_valid || s_valid) n++;
        end
        chk({tag, " no valid"}, 64'(n), 64'd0);
    endtask

    initial begin
        rst = 1'b1; d_ena = 1'b0; s_ena = 1'b0;
        d_a = '0; d_b = '0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset res64", d_res, 64'd0);
        chk("reset flags64", 64'(flags(1'b0)), 64'd0);
        chk("reset valid/busy", {62'b0, d_valid | s_valid, d_busy | s_busy}, 64'd0);
        rst = 1'b0;

        run("f64 6/2",    0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 0);
        run("f64 1/3",    0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001, 0);
        run("f32 1/3",    1, 64'h3F800000,         64'h40400000,         64'h3EAAAAAB,         5'b00001, 0);
        run("f32 -6/2",   1, 64'hC0C00000,         64'h40000000,         64'hC0400000,         5'b00000, 0);
        run("f64 1/0",    0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b01000, 0);
        run("f64 0/0",    0, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b10000, 0);
        run("f64 snan",   0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b10000, 0);
        run("f64 inf/inf",0, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'b10000, 0);
        run("f64 -inf/2", 0, 64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 5'b00000, 0);
        run("f64 ovf",    0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101, 0);
        run("f64 unf",    0, 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011, 0);

        // Second start while busy is dropped, not queued.
        run("f64 dbl",    0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 10);
        quiet("f64 dbl", 80);

        // Reset mid-operation: outputs clear at once, op is discarded.
        @(negedge clk);
        d_ena = 1'b1; d_a = 64'h3FF0000000000000; d_b = 64'h4008000000000000;
        @(negedge clk);
        d_ena = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst res", d_res, 64'd0);
        chk("midrst flags", 64'(flags(1'b0)), 64'd0);
        chk("midrst valid/busy", {62'b0, d_valid, d_busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet("midrst", 80);
        run("f64 post-rst", 0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 0);

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fdiv_generic.md
# fdiv_generic

Parametrised iterative IEEE-754 floating-point divider for the River FPU, generalising the fixed double-precision divider to any binary format via exponent/mantissa width parameters (F32, F64 instances). It sits in the FPU execute stage beside the add/mul units, accepts one operation at a time through a pulse-in/pulse-out handshake, and produces a rounded (round-to-nearest-even) quotient plus exception flags after a fixed, format-dependent latency.

## Interface
- EXP_W, 11, exponent field width; F32 = 8.
- MANT_W, 52, stored fraction width, hidden bit excluded; F32 = 23.
- Derived: W = 1+EXP_W+MANT_W; BIAS = 2^(EXP_W-1)-1; LATENCY = MANT_W+6.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ena  in  1  start pulse; sampled only when o_busy=0.
- i_a  in  W  dividend.
- i_b  in  W  divisor.
- o_res  out  W  quotient; valid while o_valid=1, held until next start.
- o_valid  out  1  one-cycle completion pulse.
- o_busy  out  1  operation in progress.
- o_illegal_op  out  1  invalid operation (0/0, inf/inf, any sNaN input).
- o_divbyzero  out  1  finite nonzero / zero.
- o_overflow  out  1  rounded result exceeds max finite.
- o_underflow  out  1  result below min normal, flushed to zero.
- o_inexact  out  1  rounding discarded nonzero bits (includes overflow/underflow).

## Operation
- FSM: IDLE -> UNPACK (1 cycle) -> DIVIDE (MANT_W+3 cycles, counter) -> ROUND (1 cycle) -> DONE (o_valid=1, 1 cycle) -> IDLE.
- IDLE: i_ena=1 latches i_a, i_b; o_busy=1 from next cycle until DONE inclusive. i_ena while busy is ignored, not queued.
- UNPACK: sign = sa^sb; subnormal inputs treated as zero (flush); mantissas get hidden bit (MANT_W+1 bits); exponent diff = ea-eb+BIAS in EXP_W+2 signed bits; special-case class decided here.
- DIVIDE: restoring radix-2, one quotient bit per cycle; rem starts = ma; each step: bit = (rem>=mb), rem -= bit?mb:0, rem <<= 1. Produces q[MANT_W+2:0] = integer bit, MANT_W fraction, guard, round; sticky = (final rem != 0).
- ROUND: if q integer bit = 0, shift left 1, exponent-1. RNE on guard/round/sticky; mantissa carry-out increments exponent.
- Range: exp >= 2^EXP_W-1 -> signed inf, overflow+inexact. exp <= 0 -> signed zero, underflow+inexact (no subnormal output).
- Specials (override datapath, same fixed latency): any NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB only); illegal_op only for sNaN, 0/0, inf/inf. x/0 (x finite nonzero) -> signed inf, divbyzero. 0/x, finite/inf -> signed zero. inf/finite -> signed inf. No other flags set with specials.
- Flags and o_res update together in ROUND, held until next accepted start.

## Timing
- Start accepted at cycle 0 -> o_valid high in cycle LATENCY (F64: 58, F32: 29), for all inputs including specials.
- Back-to-back: next i_ena accepted the cycle after o_valid (o_busy=0 then).
- Reset (any time, including mid-operation): FSM to IDLE; o_res, all flags, o_valid, o_busy = 0; in-flight op discarded, no o_valid emitted.
- i_a/i_b may change after the start cycle without effect.

## Test plan
- F64 0x4018000000000000 / 0x4000000000000000 -> o_res 0x4008000000000000, no flags, o_valid exactly 58 cycles after i_ena.
- F64 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555, inexact only; F32 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, inexact, latency 29.
- F64 1.0 / +0 -> 0x7FF0000000000000, divbyzero; 0/0 -> 0x7FF8000000000000, illegal_op; sNaN 0x7FF0000000000001 / 1.0 -> 0x7FF8000000000000, illegal_op.
- F64 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000, overflow+inexact; 0x0010000000000000 / 0x4000000000000000 -> 0x0000000000000000, underflow+inexact.
- i_ena pulsed at cycles 0 and 10 -> single o_valid at 58 for first op; second op ignored.
- i_rst at cycle 20 of an op -> all outputs 0 immediately, no o_valid; new start after release completes normally.
